// File: rtl/magic_ctl.sv
// magic_ctl: magic-mode controller. Arbitrates NMI request sources, drives
// n_nmi with an acknowledge watchdog, maps/unmaps the magic ROM (validated
// by a signature opcode on the first fetch after entry), and exposes a
// config register file plus a status/cause byte on an I/O port.
module magic_ctl #(
  parameter int                  N_SRC        = 2,
  parameter int                  N_REGS       = 12,
  parameter logic [N_REGS*8-1:0] CFG_RESET    = {(N_REGS*8){1'b0}},
  parameter logic [7:0]          CFG_PORT     = 8'hFF,
  parameter logic [15:0]         NMI_VEC      = 16'h0066,
  parameter logic [7:0]          SIG_OPCODE   = 8'hEB,
  parameter logic [15:0]         EXIT_ADDR    = 16'hF000,
  parameter logic [15:0]         REENTER_ADDR = 16'hF008,
  parameter int                  WD_CYCLES    = 1048576
) (
  input  logic                  clk28,
  input  logic                  rst_n,
  input  logic [15:0]           bus_a,
  input  logic [7:0]            bus_d,
  input  logic                  bus_mreq,
  input  logic                  bus_ioreq,
  input  logic                  bus_m1,
  input  logic                  bus_rd,
  input  logic                  bus_wr,
  input  logic                  n_int,
  input  logic                  n_int_next,
  input  logic [N_SRC-1:0]      src_req,
  input  logic [3:0]            status_in,
  output logic                  n_nmi,
  output logic                  magic_mode,
  output logic                  magic_map,
  output logic [N_REGS*8-1:0]   cfg,
  output logic [7:0]            d_out,
  output logic                  d_out_active
);

  localparam int WD_W = (WD_CYCLES > 2) ? $clog2(WD_CYCLES) : 1;
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(WD_CYCLES - 1);

  // Signature check: armed after entry at NMI_VEC, SEEN once the first
  // opcode fetch has been latched, applied when that fetch ends.
  typedef enum logic [1:0] {
    SIG_OFF  = 2'b00,
    SIG_WAIT = 2'b01,
    SIG_SEEN = 2'b10
  } sig_state_t;

  // Index of the highest-priority (lowest-numbered) active request.
  function automatic logic [2:0] lowest_set(input logic [N_SRC-1:0] req);
    logic [2:0] idx;
    idx = 3'd0;
    for (int i = N_SRC - 1; i >= 0; i--) begin
      if (req[i]) begin
        idx = 3'(i);
      end else begin
        idx = idx;
      end
    end
    return idx;
  endfunction

  // Registered state
  logic             n_nmi_r;
  logic             magic_mode_r;
  logic             magic_map_r;
  sig_state_t       sig_state_r;
  logic             sig_match_r;
  logic             map_next_r;
  logic             unmap_next_r;
  logic [2:0]       cause_r;
  logic [WD_W-1:0]  wd_cnt_r;
  logic [7:0]       cfg_r [N_REGS];
  logic [7:0]       d_out_r;
  logic             d_out_active_r;

  // Next-state values
  logic             n_nmi_s;
  logic             magic_mode_s;
  logic             magic_map_s;
  sig_state_t       sig_state_s;
  logic             sig_match_s;
  logic             map_next_s;
  logic             unmap_next_s;
  logic [2:0]       cause_s;
  logic [WD_W-1:0]  wd_cnt_s;

  // Bus decode
  logic       m1_rd_s;
  logic       mem_rd_s;
  logic       exit_hit_s;
  logic       reenter_hit_s;
  logic       unmap_hit_s;
  logic       remap_hit_s;
  logic       int_fall_s;
  logic [7:0] idx_s;
  logic       port_hit_s;
  logic       idx_ok_s;
  logic       cfg_wr_s;
  logic       rd_hit_s;
  logic [7:0] rd_data_s;

  assign m1_rd_s       = bus_mreq & bus_m1 & bus_rd;
  assign mem_rd_s      = bus_mreq & bus_rd;
  assign exit_hit_s    = magic_map_r & mem_rd_s & (bus_a == EXIT_ADDR) & ~map_next_r;
  assign reenter_hit_s = magic_map_r & mem_rd_s & (bus_a == REENTER_ADDR);
  assign unmap_hit_s   = unmap_next_r & ~bus_mreq;
  assign remap_hit_s   = magic_mode_r & bus_m1 & bus_mreq & ((bus_a == NMI_VEC) | map_next_r);
  assign int_fall_s    = n_int & ~n_int_next;

  assign idx_s      = bus_a[15:8];
  assign port_hit_s = (bus_a[7:0] == CFG_PORT);
  // Index 8'hFF is reserved for status even when N_REGS is 255.
  assign idx_ok_s   = ({1'b0, idx_s} < 9'(N_REGS));
  // Writes and reads see the mapping as registered at cycle start.
  assign cfg_wr_s   = magic_map_r & bus_ioreq & bus_wr & port_hit_s & idx_ok_s;
  assign rd_hit_s   = magic_map_r & bus_ioreq & bus_rd & port_hit_s &
                      (idx_ok_s | (idx_s == 8'hFF));

  // Next-state: map chain first, then the NMI request, then the watchdog,
  // so a later stage overrides an earlier one when both touch a signal.
  always_comb begin
    n_nmi_s      = n_nmi_r;
    magic_mode_s = magic_mode_r;
    magic_map_s  = magic_map_r;
    sig_state_s  = sig_state_r;
    sig_match_s  = sig_match_r;
    map_next_s   = map_next_r;
    unmap_next_s = unmap_next_r;
    cause_s      = cause_r;
    wd_cnt_s     = wd_cnt_r;

    // Map chain, first match wins
    if (sig_state_r != SIG_OFF) begin
      case (sig_state_r)
        SIG_WAIT: begin
          if (m1_rd_s) begin
            sig_match_s = (bus_d == SIG_OPCODE);
            sig_state_s = SIG_SEEN;
          end else begin
            sig_state_s = SIG_WAIT;
          end
        end
        SIG_SEEN: begin
          if (!m1_rd_s) begin
            sig_state_s  = SIG_OFF;
            magic_mode_s = magic_mode_r & sig_match_r;
            magic_map_s  = magic_map_r & sig_match_r;
          end else begin
            sig_state_s = SIG_SEEN;
          end
        end
        default: sig_state_s = SIG_OFF;
      endcase
    end else if (exit_hit_s) begin
      unmap_next_s = 1'b1;
      magic_mode_s = 1'b0;
    end else if (reenter_hit_s) begin
      unmap_next_s = 1'b1;
      map_next_s   = 1'b1;
    end else if (unmap_hit_s) begin
      magic_map_s  = 1'b0;
      unmap_next_s = 1'b0;
    end else if (remap_hit_s) begin
      n_nmi_s     = 1'b1;
      magic_map_s = 1'b1;
      map_next_s  = 1'b0;
      sig_state_s = (bus_a == NMI_VEC) ? SIG_WAIT : SIG_OFF;
    end else begin
      sig_state_s = sig_state_r;
    end

    // NMI request: only sampled on an INT falling edge, never queued
    if (int_fall_s && (|src_req)) begin
      cause_s      = lowest_set(src_req);
      magic_mode_s = 1'b1;
      if (!magic_mode_r) begin
        n_nmi_s = 1'b0;
      end else begin
        n_nmi_s = n_nmi_s;
      end
    end else begin
      cause_s = cause_s;
    end

    // Acknowledge watchdog: abandon an NMI the CPU never takes
    if (!n_nmi_r) begin
      if (wd_cnt_r == WD_LAST) begin
        n_nmi_s      = 1'b1;
        magic_mode_s = 1'b0;
        wd_cnt_s     = {WD_W{1'b0}};
      end else begin
        wd_cnt_s = wd_cnt_r + WD_W'(1);
      end
    end else begin
      wd_cnt_s = {WD_W{1'b0}};
    end
  end

  // Readback mux: status byte at 8'hFF, otherwise the addressed register.
  always_comb begin
    rd_data_s = 8'h00;
    if (idx_s == 8'hFF) begin
      rd_data_s = {1'b0, cause_r, status_in};
    end else begin
      for (int i = 0; i < N_REGS; i++) begin
        rd_data_s = (idx_s == 8'(i)) ? cfg_r[i] : rd_data_s;
      end
    end
  end

  // Control state register
  always_ff @(posedge clk28 or negedge rst_n) begin
    if (!rst_n) begin
      n_nmi_r      <= 1'b1;
      magic_mode_r <= 1'b1;
      magic_map_r  <= 1'b1;
      sig_state_r  <= SIG_WAIT;
      sig_match_r  <= 1'b0;
      map_next_r   <= 1'b0;
      unmap_next_r <= 1'b0;
      cause_r      <= 3'd0;
      wd_cnt_r     <= {WD_W{1'b0}};
    end else begin
      n_nmi_r      <= n_nmi_s;
      magic_mode_r <= magic_mode_s;
      magic_map_r  <= magic_map_s;
      sig_state_r  <= sig_state_s;
      sig_match_r  <= sig_match_s;
      map_next_r   <= map_next_s;
      unmap_next_r <= unmap_next_s;
      cause_r      <= cause_s;
      wd_cnt_r     <= wd_cnt_s;
    end
  end

  // Config register file, written every cycle of a decoded I/O write
  always_ff @(posedge clk28 or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N_REGS; i++) begin
        cfg_r[i] <= CFG_RESET[8*i +: 8];
      end
    end else begin
      for (int i = 0; i < N_REGS; i++) begin
        if (cfg_wr_s && (idx_s == 8'(i))) begin
          cfg_r[i] <= bus_d;
        end else begin
          cfg_r[i] <= cfg_r[i];
        end
      end
    end
  end

  // Registered readback, one cycle after the I/O read strobe
  always_ff @(posedge clk28 or negedge rst_n) begin
    if (!rst_n) begin
      d_out_r        <= 8'h00;
      d_out_active_r <= 1'b0;
    end else begin
      d_out_active_r <= rd_hit_s;
      d_out_r        <= rd_hit_s ? rd_data_s : 8'h00;
    end
  end

  // Flatten the register file onto the output bus
  for (genvar g = 0; g < N_REGS; g++) begin : g_cfg_out
    assign cfg[8*g +: 8] = cfg_r[g];
  end

  assign n_nmi        = n_nmi_r;
  assign magic_mode   = magic_mode_r;
  assign magic_map    = magic_map_r;
  assign d_out        = d_out_r;
  assign d_out_active = d_out_active_r;

endmodule

// File: tb/tb_magic_ctl.sv
// Self-checking bench for magic_ctl: reset, signature check, NMI entry,
// config table vectors, randomized register traffic against an array model,
// exit/re-enter, watchdog and asynchronous reset mid-session.
module tb_magic_ctl;

  localparam int N_SRC  = 2;
  localparam int N_REGS = 12;
  // Byte i resets to 8'h10 + i so the reset image is observable.
  localparam logic [95:0] CFG_INIT = 96'h1B1A_1918_1716_1514_1312_1110;

  logic                clk28;
  logic                rst_n;
  logic [15:0]         bus_a;
  logic [7:0]          bus_d;
  logic                bus_mreq, bus_ioreq, bus_m1, bus_rd, bus_wr;
  logic                n_int, n_int_next;
  logic [N_SRC-1:0]    src_req;
  logic [3:0]          status_in;
  logic                n_nmi, magic_mode, magic_map, d_out_active;
  logic [N_REGS*8-1:0] cfg;
  logic [7:0]          d_out;

  magic_ctl #(
    .N_SRC(N_SRC), .N_REGS(N_REGS), .CFG_RESET(CFG_INIT), .WD_CYCLES(16)
  ) dut (
    .clk28(clk28), .rst_n(rst_n),
    .bus_a(bus_a), .bus_d(bus_d), .bus_mreq(bus_mreq), .bus_ioreq(bus_ioreq),
    .bus_m1(bus_m1), .bus_rd(bus_rd), .bus_wr(bus_wr),
    .n_int(n_int), .n_int_next(n_int_next), .src_req(src_req),
    .status_in(status_in), .n_nmi(n_nmi), .magic_mode(magic_mode),
    .magic_map(magic_map), .cfg(cfg), .d_out(d_out), .d_out_active(d_out_active)
  );

  initial begin
    clk28 = 1'b0;
    forever #5 clk28 = ~clk28;
  end

  initial begin
    #200000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1, "timeout");
  end

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state
  logic [7:0] cfg_m [N_REGS];
  logic [2:0] cause_m;

  task automatic chk(input string name, input logic [95:0] act, input logic [95:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic mdl_reset();
    for (int i = 0; i < N_REGS; i++) cfg_m[i] = CFG_INIT[8*i +: 8];
    cause_m = 3'd0;
  endtask

  task automatic mdl_write(input logic [7:0] idx, input logic [7:0] port, input logic [7:0] d);
    if (port == 8'hFF && idx < 8'(N_REGS)) cfg_m[idx[3:0]] = d;
  endtask

  // Lowest set bit index via isolate-then-log2
  task automatic mdl_request(input logic [N_SRC-1:0] src);
    int v;
    v = int'(src);
    if (v != 0) cause_m = 3'($clog2(v & -v));
  endtask

  function automatic logic [95:0] mdl_flat();
    logic [95:0] v;
    for (int i = 0; i < N_REGS; i++) v[8*i +: 8] = cfg_m[i];
    return v;
  endfunction

  task automatic idle();
    bus_a = 16'h0000; bus_d = 8'h00;
    bus_mreq = 1'b0; bus_ioreq = 1'b0; bus_m1 = 1'b0; bus_rd = 1'b0; bus_wr = 1'b0;
    n_int = 1'b1; n_int_next = 1'b1; src_req = '0;
  endtask

  task automatic cyc();
    @(posedge clk28);
    #1;
  endtask

  task automatic fetch(input logic [15:0] a, input logic [7:0] d);
    idle(); bus_a = a; bus_d = d; bus_mreq = 1'b1; bus_m1 = 1'b1; bus_rd = 1'b1;
    cyc(); idle();
  endtask

  task automatic memrd(input logic [15:0] a);
    idle(); bus_a = a; bus_mreq = 1'b1; bus_rd = 1'b1;
    cyc(); idle();
  endtask

  task automatic iowr(input logic [15:0] a, input logic [7:0] d);
    idle(); bus_a = a; bus_d = d; bus_ioreq = 1'b1; bus_wr = 1'b1;
    cyc(); idle(); cyc();
  endtask

  task automatic iord(input logic [15:0] a);
    idle(); bus_a = a; bus_ioreq = 1'b1; bus_rd = 1'b1;
    cyc(); idle();
  endtask

  task automatic nmi_req(input logic [N_SRC-1:0] src);
    idle(); n_int_next = 1'b0; src_req = src;
    cyc(); idle();
  endtask

  typedef struct {
    logic [7:0] idx;
    logic [7:0] wdata;
    logic       exp_act;
    logic [7:0] exp_rd;
  } vec_t;

  vec_t tbl [5];

  initial begin
    int cnt;
    logic [7:0] ridx, rport, rdat, exp_d;
    logic exp_act;

    tbl[0] = '{idx: 8'd3,   wdata: 8'h5A, exp_act: 1'b1, exp_rd: 8'h5A};
    tbl[1] = '{idx: 8'd0,   wdata: 8'hA5, exp_act: 1'b1, exp_rd: 8'hA5};
    tbl[2] = '{idx: 8'd11,  wdata: 8'h3C, exp_act: 1'b1, exp_rd: 8'h3C};
    tbl[3] = '{idx: 8'd12,  wdata: 8'h99, exp_act: 1'b0, exp_rd: 8'h00};
    tbl[4] = '{idx: 8'h20,  wdata: 8'h42, exp_act: 1'b0, exp_rd: 8'h00};

    mdl_reset();
    idle();
    status_in = 4'hA;
    rst_n = 1'b0;
    repeat (3) @(posedge clk28);
    #1;
    chk("rst_n_nmi", n_nmi, 1'b1);
    chk("rst_mode", magic_mode, 1'b1);
    chk("rst_map", magic_map, 1'b1);
    chk("rst_dact", d_out_active, 1'b0);
    chk("rst_cfg", cfg, CFG_INIT);
    rst_n = 1'b1;

    // Good signature keeps magic mode
    fetch(16'h0000, 8'hEB);
    chk("sig_ok_mode_a", magic_mode, 1'b1);
    cyc();
    chk("sig_ok_mode", magic_mode, 1'b1);
    chk("sig_ok_map", magic_map, 1'b1);

    // Bad signature drops mode and map one cycle after the fetch ends
    rst_n = 1'b0; #2; rst_n = 1'b1;
    fetch(16'h0000, 8'h00);
    chk("sig_bad_mode_hold", magic_mode, 1'b1);
    cyc();
    chk("sig_bad_mode", magic_mode, 1'b0);
    chk("sig_bad_map", magic_map, 1'b0);

    // Unmapped: writes and reads ignored
    iowr(16'h03FF, 8'h77);
    chk("wr_unmapped", cfg, mdl_flat());
    iord(16'h03FF);
    chk("rd_unmapped_act", d_out_active, 1'b0);
    cyc();

    // NMI entry with both sources: lowest index wins
    nmi_req(2'b11); mdl_request(2'b11);
    chk("nmi_low", n_nmi, 1'b0);
    chk("nmi_mode", magic_mode, 1'b1);
    cyc();
    fetch(16'h0066, 8'hF3);
    chk("nmi_ack", n_nmi, 1'b1);
    chk("nmi_map", magic_map, 1'b1);
    cyc();
    idle(); bus_a = 16'hFFFF; bus_ioreq = 1'b1; bus_rd = 1'b1;
    chk("stat_act_before", d_out_active, 1'b0);
    cyc(); idle();
    chk("stat_act", d_out_active, 1'b1);
    chk("stat0", d_out, {1'b0, cause_m, status_in});
    cyc();
    fetch(16'h0067, 8'hEB);
    cyc();
    // Request while in magic mode: cause updates, n_nmi stays high
    nmi_req(2'b10); mdl_request(2'b10);
    chk("nmi_in_magic", n_nmi, 1'b1);
    iord(16'hFFFF);
    chk("stat1", d_out, {1'b0, cause_m, status_in});
    cyc();

    // Table-driven config write/readback
    for (int i = 0; i < 5; i++) begin
      iowr({tbl[i].idx, 8'hFF}, tbl[i].wdata);
      mdl_write(tbl[i].idx, 8'hFF, tbl[i].wdata);
      iord({tbl[i].idx, 8'hFF});
      chk("tbl_act", d_out_active, tbl[i].exp_act);
      if (tbl[i].exp_act) chk("tbl_data", d_out, tbl[i].exp_rd);
      cyc();
    end
    chk("tbl_cfg", cfg, mdl_flat());

    // Randomized register traffic against the array model
    for (int r = 0; r < 80; r++) begin
      ridx  = ($urandom_range(0, 3) == 0) ? 8'hFF : 8'($urandom_range(0, 15));
      rport = ($urandom_range(0, 7) == 0) ? 8'hFE : 8'hFF;
      rdat  = 8'($urandom);
      status_in = 4'($urandom);
      if ($urandom_range(0, 1) == 1) begin
        iowr({ridx, rport}, rdat);
        mdl_write(ridx, rport, rdat);
      end else begin
        iord({ridx, rport});
        exp_act = (rport == 8'hFF) && ((ridx < 8'(N_REGS)) || (ridx == 8'hFF));
        exp_d   = (ridx == 8'hFF) ? {1'b0, cause_m, status_in} : cfg_m[ridx[3:0]];
        chk("rnd_act", d_out_active, exp_act);
        if (exp_act) chk("rnd_data", d_out, exp_d);
        cyc();
      end
    end
    chk("rnd_cfg", cfg, mdl_flat());

    // Exit: mode drops at once, map on first cycle without mreq
    memrd(16'hF000);
    chk("exit_mode", magic_mode, 1'b0);
    chk("exit_map_hold", magic_map, 1'b1);
    cyc();
    chk("exit_map", magic_map, 1'b0);

    // Re-enter: unmap, then remap at next M1 with no signature check
    nmi_req(2'b01); mdl_request(2'b01);
    fetch(16'h0066, 8'h00);
    cyc();
    fetch(16'h0067, 8'hEB);
    cyc();
    chk("reent_pre_mode", magic_mode, 1'b1);
    memrd(16'hF008);
    chk("reent_map_hold", magic_map, 1'b1);
    cyc();
    chk("reent_unmap", magic_map, 1'b0);
    chk("reent_mode", magic_mode, 1'b1);
    fetch(16'h1234, 8'h00);
    chk("reent_remap", magic_map, 1'b1);
    cyc();
    fetch(16'h1235, 8'h00);
    cyc();
    chk("reent_nosig_mode", magic_mode, 1'b1);
    chk("reent_nosig_map", magic_map, 1'b1);

    // Watchdog: unacknowledged NMI released after 16 cycles
    memrd(16'hF000);
    cyc();
    nmi_req(2'b10); mdl_request(2'b10);
    chk("wd_low", n_nmi, 1'b0);
    cnt = 0;
    while (n_nmi == 1'b0 && cnt < 40) begin
      cyc();
      cnt++;
    end
    chk("wd_cycles", cnt, 16);
    chk("wd_mode", magic_mode, 1'b0);

    // Asynchronous reset mid-session
    nmi_req(2'b01); mdl_request(2'b01);
    fetch(16'h0066, 8'h00);
    cyc();
    iowr(16'h03FF, 8'h5A);
    chk("pre_rst_cfg3", cfg[31:24], 8'h5A);
    @(posedge clk28); #2;
    rst_n = 1'b0;
    #1;
    chk("arst_cfg3", cfg[31:24], CFG_INIT[31:24]);
    chk("arst_n_nmi", n_nmi, 1'b1);
    chk("arst_mode", magic_mode, 1'b1);
    chk("arst_map", magic_map, 1'b1);
    cyc();
    rst_n = 1'b1;
    mdl_reset();
    fetch(16'h0000, 8'h00);
    cyc();
    chk("reboot_sig_mode", magic_mode, 1'b0);
    chk("reboot_sig_map", magic_map, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/magic_ctl.md
Name: magic_ctl

Overview:
- Parametrised successor of the magic-mode controller: arbitrates N_SRC NMI request sources and drives n_nmi.
- Maps and unmaps the magic ROM and validates it by a signature opcode.
- Exposes a generic N_REGS x 8-bit readable/writable config register file on an I/O port, plus a status/cause byte.
- Sits between the cpu_bus and the machine/ROM/peripheral config consumers; adds cause latching, register readback and an NMI-acknowledge watchdog.

Parameters:
N_SRC, 2, number of NMI request sources (1..8); bit 0 highest priority
N_REGS, 12, number of config registers (1..255), indexed by bus.a[15:8]
CFG_RESET, all-zero, N_REGS*8-bit reset image; register i = bits [8*i+7:8*i]
CFG_PORT, 8'hFF, bus.a[7:0] decode for config/status I/O
NMI_VEC, 16'h0066, NMI entry address
SIG_OPCODE, 8'hEB, required first opcode fetched from magic ROM
EXIT_ADDR, 16'hF000, read here leaves magic mode
REENTER_ADDR, 16'hF008, read here unmaps, then remaps at next M1
WD_CYCLES, 1048576, clk28 cycles n_nmi may stay low unacknowledged

Ports:
clk28  input  1  system clock
rst_n  input  1  asynchronous active-low reset
bus  interface  cpu_bus  CPU bus (a, d, mreq, ioreq, m1, rd, wr)
n_int  input  1  current INT level
n_int_next  input  1  INT level next cycle; falling edge = n_int=1 && n_int_next=0
src_req  input  N_SRC  NMI request levels (magic button, pause, …)
status_in  input  4  external status bits (e.g. div_automap, sd_cd)
n_nmi  output  1  NMI to CPU, active low
magic_mode  output  1  magic session active
magic_map  output  1  magic ROM mapped
cfg  output  N_REGS*8  flat config register file
d_out  output  8  read data
d_out_active  output  1  d_out drive enable

Behaviour:
- Reset (async): n_nmi=1, magic_mode=1, magic_map=1, sig_check armed, map_next=0, unmap_next=0, cause=0, wd counter=0, cfg=CFG_RESET, d_out_active=0.
- NMI request, evaluated every cycle independently of the map chain:
  - On an INT falling edge with |src_req: cause <= index of lowest set bit (3 bits).
  - If !magic_mode: also n_nmi<=0. magic_mode<=1 in all cases.
  - Requests at other times are ignored, not queued.
- Watchdog:
  - Counter runs while n_nmi=0 and is cleared when n_nmi=1.
  - On reaching WD_CYCLES-1: n_nmi<=1, magic_mode<=0, counter<=0.
  - Watchdog overrides a same-cycle request.
- Map chain, priority order, first match wins:
  1. sig_check armed: the first mreq&&m1&&rd cycle latches match=(bus.d==SIG_OPCODE). On the first following cycle without that condition: disarm, magic_mode&=match, magic_map&=match.
  2. magic_map && mreq && rd && a==EXIT_ADDR && !map_next: unmap_next<=1, magic_mode<=0.
  3. magic_map && mreq && rd && a==REENTER_ADDR: unmap_next<=1, map_next<=1.
  4. unmap_next && !mreq: magic_map<=0, unmap_next<=0.
  5. magic_mode && m1 && mreq && (a==NMI_VEC || map_next): n_nmi<=1, magic_map<=1, map_next<=0, sig_check armed iff a==NMI_VEC.
- Config write:
  - Condition: magic_map && ioreq && wr && a[7:0]==CFG_PORT && a[15:8]<N_REGS → cfg[a[15:8]]<=d.
  - Applied every cycle of the strobe (idempotent). Out-of-range index is ignored.
- Readback:
  - Registered, 1-cycle latency: d_out_active <= magic_map && ioreq && rd && a[7:0]==CFG_PORT && (a[15:8]<N_REGS || a[15:8]==8'hFF).
  - d_out = cfg[idx] for idx<N_REGS; for idx 8'hFF, d_out = {1'b0, cause, status_in}.
  - Index 8'hFF always reads status, even if N_REGS would cover it (N_REGS max 255).
- Simultaneous config write and map change in one cycle: the write uses magic_map as registered at cycle start.
- Reset mid-session: all state returns to reset values immediately; boot re-enters magic with signature check.

Test Plan:
- Reset, CPU fetches 0xEB at 0x0000 → magic_mode=1, magic_map=1 retained; fetch 0x00 instead → both 0 one cycle after M1 read ends.
- magic_mode=0, src_req=2'b11, INT falling edge → n_nmi=0, cause=0; M1 fetch at 0x0066 → n_nmi=1, magic_map=1; read 0xFF at port 0xFFFF → d_out={1'b0,3'd0,status_in}, d_out_active one cycle later.
- magic_map=1, IO write 0x5A to 0x03FF → cfg[3]=0x5A; read 0x03FF → d_out=0x5A; write to 0x20FF (N_REGS=12) → no cfg change; write with magic_map=0 → ignored.
- Read at 0xF000 → magic_mode=0 immediately, magic_map=0 on first !mreq cycle; read at 0xF008 → unmapped, then next M1 (any address) remaps with no signature check.
- Request raised, no M1 at 0x0066 for WD_CYCLES (set 16 in bench) → n_nmi returns 1 and magic_mode=0 at cycle 16.
- Assert rst_n=0 mid-session with cfg[3]=0x5A → cfg[3]=CFG_RESET byte, n_nmi=1, magic_mode=magic_map=1 asynchronously.
